mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (instruction fetch / data) round-robin arbiter onto a
// single downstream memory bus, with an optional wait-state timeout abort.
//
// Ports
//   clk, reset              single clock, asynchronous active-low reset
//   i_valid/i_addr          fetch request      -> i_ready/i_rdata completion
//   d_valid/d_addr/d_wdata/
//   d_wstrb                 data request       -> d_ready/d_rdata completion
//   mem_valid/mem_instr/
//   mem_addr/mem_wdata/
//   mem_wstrb               downstream request (held stable while mem_valid)
//   mem_ready/mem_rdata     downstream completion
//   bus_err                 one-cycle pulse when a transaction is aborted
//
// TIMEOUT: max wait cycles for mem_ready before abort; 0 disables the abort.
module mem_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  input  logic [31:0] i_addr,
  output logic        i_ready,
  output logic [31:0] i_rdata,
  input  logic        d_valid,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        d_ready,
  output logic [31:0] d_rdata,
  output logic        mem_valid,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        bus_err
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_V = CW'(TIMEOUT);

  typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } req_t;

  state_t          state_q, state_d;
  req_t            req_q, req_d;
  logic [CW-1:0]   wait_cnt_q, wait_cnt_d;
  logic            last_d_q, last_d_d;   // 1: data port was served last

  logic granted, tmo, done, gnt_i, gnt_d;

  // Round-robin: on a tie, the port not served last wins.
  assign gnt_i   = i_valid && (!d_valid || last_d_q);
  assign gnt_d   = d_valid && (!i_valid || !last_d_q);
  assign granted = (state_q != IDLE);
  // Abort only when mem_ready is low; a late ready still completes normally.
  assign tmo     = (TIMEOUT != 0) && granted && (wait_cnt_q == TO_V) && !mem_ready;
  assign done    = granted && (mem_ready || tmo);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      req_q      <= '0;
      wait_cnt_q <= '0;
      last_d_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      wait_cnt_q <= wait_cnt_d;
      last_d_q   <= last_d_d;
    end
  end

  // Next state and datapath
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    wait_cnt_d = wait_cnt_q;
    last_d_d   = last_d_q;
    unique case (state_q)
      IDLE: begin
        wait_cnt_d = '0;
        if (gnt_i) begin
          state_d = GNT_I;
          req_d   = '{addr: i_addr, wdata: 32'h0, wstrb: 4'h0};
        end else if (gnt_d) begin
          state_d = GNT_D;
          req_d   = '{addr: d_addr, wdata: d_wdata, wstrb: d_wstrb};
        end
      end
      GNT_I, GNT_D: begin
        if (done) begin
          state_d    = IDLE;
          wait_cnt_d = '0;
          last_d_d   = (state_q == GNT_D);
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    mem_valid = granted;
    mem_instr = (state_q == GNT_I);
    mem_addr  = req_q.addr;
    mem_wdata = req_q.wdata;
    mem_wstrb = req_q.wstrb;
    i_ready   = (state_q == GNT_I) && done;
    d_ready   = (state_q == GNT_D) && done;
    i_rdata   = ((state_q == GNT_I) && mem_ready) ? mem_rdata : 32'h0;
    d_rdata   = ((state_q == GNT_D) && mem_ready) ? mem_rdata : 32'h0;
    bus_err   = tmo;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations plus a
// randomized phase checked every cycle against a transaction-level model.
module tb_mem_arbiter;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_valid, d_valid, mem_ready;
  logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
  logic [3:0]  d_wstrb;
  logic        i_ready, d_ready, mem_valid, mem_instr, bus_err;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: the in-flight transaction (owner, captured
  // request, cycles spent waiting) and who was served last.
  int          m_port;   // 0 none, 1 fetch, 2 data
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  int          m_age;
  bit          m_last_d;
  bit          e_tmo, e_done;

  always @(negedge clk) begin
    if (!reset) begin
      m_port = 0; m_addr = 0; m_wdata = 0; m_wstrb = 0; m_age = 0; m_last_d = 1;
    end
    e_tmo  = (m_port != 0) && (TO != 0) && (m_age == TO) && !mem_ready;
    e_done = (m_port != 0) && (mem_ready || e_tmo);
    chk("mem_valid", mem_valid, m_port != 0);
    chk("mem_instr", mem_instr, m_port == 1);
    chk("mem_addr",  mem_addr,  m_addr);
    chk("mem_wdata", mem_wdata, m_wdata);
    chk("mem_wstrb", mem_wstrb, m_wstrb);
    chk("i_ready",   i_ready,   (m_port == 1) && e_done);
    chk("d_ready",   d_ready,   (m_port == 2) && e_done);
    chk("i_rdata",   i_rdata,   ((m_port == 1) && mem_ready) ? mem_rdata : 32'h0);
    chk("d_rdata",   d_rdata,   ((m_port == 2) && mem_ready) ? mem_rdata : 32'h0);
    chk("bus_err",   bus_err,   e_tmo);
    if (reset) begin
      if (m_port != 0) begin
        if (e_done) begin
          m_last_d = (m_port == 2);
          m_port   = 0;
        end else begin
          m_age++;
        end
      end else if (i_valid || d_valid) begin
        m_age = 0;
        if (i_valid && (!d_valid || m_last_d)) begin
          m_port = 1; m_addr = i_addr; m_wdata = 0; m_wstrb = 0;
        end else begin
          m_port = 2; m_addr = d_addr; m_wdata = d_wdata; m_wstrb = d_wstrb;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr();
    i_valid = 0; d_valid = 0; mem_ready = 0;
    i_addr = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0; mem_rdata = 0;
  endtask

  initial begin
    reset = 1'b0;
    clr();
    repeat (2) tick();
    chk("rst_mem_valid", mem_valid, 1'b0);
    chk("rst_mem_addr",  mem_addr,  32'h0);
    chk("rst_bus_err",   bus_err,   1'b0);
    reset = 1'b1;
    tick();

    // Single fetch, mem_ready two cycles after mem_valid
    i_valid = 1; i_addr = 32'h100;
    tick();
    i_valid = 0;
    #1;
    chk("f_valid", mem_valid, 1'b1);
    chk("f_instr", mem_instr, 1'b1);
    chk("f_wstrb", mem_wstrb, 4'h0);
    chk("f_addr",  mem_addr,  32'h100);
    tick();
    chk("f_noready", i_ready, 1'b0);
    tick();
    mem_ready = 1; mem_rdata = 32'h13;
    #1;
    chk("f_iready", i_ready, 1'b1);
    chk("f_irdata", i_rdata, 32'h13);
    chk("f_dready", d_ready, 1'b0);
    tick();
    mem_ready = 0;
    #1;
    chk("f_idle", mem_valid, 1'b0);

    // Tie after reset: I, D, I, D with one idle cycle between beats
    reset = 0; tick(); reset = 1;
    i_valid = 1; i_addr = 32'h300;
    d_valid = 1; d_addr = 32'h200; d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    mem_ready = 1; mem_rdata = 32'h77;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("tie_valid", mem_valid, (k % 2) == 0);
      if ((k % 2) == 0) begin
        chk("tie_instr", mem_instr, (k % 4) == 0);
        if ((k % 4) == 2) begin
          chk("tie_wstrb", mem_wstrb, 4'hF);
          chk("tie_wdata", mem_wdata, 32'hDEADBEEF);
          chk("tie_addr",  mem_addr,  32'h200);
        end
      end
    end
    clr();
    tick();

    // Timeout on a read with mem_ready held low
    d_valid = 1; d_addr = 32'h40; d_wstrb = 0; mem_rdata = 32'h55;
    tick();
    d_valid = 0;
    for (int k = 0; k <= TO; k++) begin
      #1;
      chk("to_valid", mem_valid, 1'b1);
      chk("to_berr",  bus_err,   k == TO);
      chk("to_dready", d_ready,  k == TO);
      if (k == TO) chk("to_drdata", d_rdata, 32'h0);
      tick();
    end
    #1;
    chk("to_idle", mem_valid, 1'b0);
    chk("to_berr_clr", bus_err, 1'b0);

    // Input churn after grant
    d_valid = 1; d_addr = 32'h40; d_wdata = 32'h11; d_wstrb = 4'h3;
    tick();
    d_addr = 32'h80; d_valid = 0; d_wstrb = 4'hC;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk("ch_addr",  mem_addr,  32'h40);
      chk("ch_wstrb", mem_wstrb, 4'h3);
      tick();
    end
    mem_ready = 1;
    #1;
    chk("ch_dready", d_ready, 1'b1);
    chk("ch_addr_end", mem_addr, 32'h40);
    tick();
    mem_ready = 0;
    #1;
    chk("ch_idle", mem_valid, 1'b0);

    // Reset in the middle of a fetch
    i_valid = 1; i_addr = 32'h500;
    tick();
    chk("mr_valid", mem_valid, 1'b1);
    reset = 0; mem_ready = 1;
    #1;
    chk("mr_abort", mem_valid, 1'b0);
    chk("mr_noready", i_ready, 1'b0);
    tick();
    reset = 1; mem_ready = 0;
    #1;
    chk("mr_idle", mem_valid, 1'b0);
    tick();
    chk("mr_regrant", mem_valid, 1'b1);
    chk("mr_instr", mem_instr, 1'b1);
    chk("mr_addr", mem_addr, 32'h500);
    i_valid = 0; mem_ready = 1;
    #1;
    chk("mr_iready", i_ready, 1'b1);
    tick();
    mem_ready = 0;

    // Randomized phase
    for (int c = 0; c < 3000; c++) begin
      tick();
      reset     = ($urandom_range(0, 299) != 0);
      i_valid   = ($urandom_range(0, 3) != 0);
      d_valid   = ($urandom_range(0, 2) != 0);
      i_addr    = $urandom;
      d_addr    = $urandom;
      d_wdata   = $urandom;
      d_wstrb   = 4'($urandom);
      mem_ready = ($urandom_range(0, 9) < 4);
      mem_rdata = $urandom;
    end
    reset = 1;
    clr();
    tick();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
